// File: rtl/regfile_pkg.sv
// Shared constants and FSM encodings for the register-file dump reader.
package regfile_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_READ  = S_READ,
    ST_DRAIN = S_DRAIN,
    ST_DONE  = S_DONE
  } dump_state_e;

endpackage

// File: rtl/dump_out_buf.sv
// Two-entry in-order FIFO of {addr,data} words feeding the dump output stream.
// Accepts a pop and a one- or two-word push in the same cycle; the caller only
// pushes when the entries left after the pop have room for the push.
module dump_out_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_all,
  input  logic              push2,
  input  logic              push1,
  input  logic              pop,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [DATA_W-1:0] w0_data,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0] w1_data,
  output logic [1:0]        count,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic [ENTRY_W-1:0] slot0, slot1;
  logic [ENTRY_W-1:0] slot0_nxt, slot1_nxt;
  logic [1:0]         count_nxt, kept;

  assign {head_addr, head_data} = slot0;

  // Next slot contents: apply the pop first, then append the pushed words.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    slot0_nxt = slot0;
    slot1_nxt = slot1;
    kept      = count;
    if (pop && count != 2'd0) begin
      slot0_nxt = slot1;
      kept      = count - 2'd1;
    end
    count_nxt = kept;
    if (push2) begin
      slot0_nxt = {w0_addr, w0_data};
      slot1_nxt = {w1_addr, w1_data};
      count_nxt = 2'd2;
    end else if (push1) begin
      if (kept == 2'd0) slot0_nxt = {w0_addr, w0_data};
      else              slot1_nxt = {w0_addr, w0_data};
      count_nxt = kept + 2'd1;
    end
  end

  // Slot and occupancy registers.
  always_ff @(posedge clk) begin
    // NOTE: state is assigned with <= so every register samples pre-edge values.
    if (rst_all) begin
      // NOTE: the two slots are reset as well so out_addr/out_data read 0, not X, after reset.
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      slot0 <= slot0_nxt;
      slot1 <= slot1_nxt;
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks every register over both read ports, streams
// {addr,data} words on a valid/ready port and accumulates an XOR checksum.
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = REG_COUNT
) (
  input  logic              clk,
  input  logic              rst_all,
  input  logic              start,
  output logic [ADDR_W-1:0] read0_addr,
  output logic [ADDR_W-1:0] read1_addr,
  input  logic [DATA_W-1:0] read0_data,
  input  logic [DATA_W-1:0] read1_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam int                PTR_W     = ADDR_W + 1;
  localparam logic [PTR_W-1:0]  END_PTR   = PTR_W'(NUM_REGS);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  dump_state_e      state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_adv;
  logic [1:0]       count;
  logic             fire, capture, single, push2, push1;

  assign read0_addr = ptr[ADDR_W-1:0];
  assign read1_addr = read0_addr + ADDR_W'(1);

  assign out_valid = (count != 2'd0);
  assign fire      = out_valid && out_ready;
  assign out_last  = out_valid && (out_addr == LAST_ADDR);
  assign busy      = (state == ST_READ) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);

  // A capture needs the buffer empty once this cycle's pop (if any) is applied.
  assign capture = (state == ST_READ) && (ptr < END_PTR) &&
                   ((count == 2'd0) || (count == 2'd1 && fire));
  // Only reachable with odd NUM_REGS: the last register has no partner word.
  assign single  = (ptr == LAST_PTR);
  assign push2   = capture && !single;
  assign push1   = capture && single;
  assign ptr_adv = ptr + (single ? PTR_W'(1) : PTR_W'(2));

  dump_out_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk       (clk),
    .rst_all   (rst_all),
    .push2     (push2),
    .push1     (push1),
    .pop       (fire),
    .w0_addr   (read0_addr),
    .w0_data   (read0_data),
    .w1_addr   (read1_addr),
    .w1_data   (read1_data),
    .count     (count),
    .head_addr (out_addr),
    .head_data (out_data)
  );

  // Next-state logic for the dump sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_READ;
      ST_READ:  if (capture && ptr_adv >= END_PTR) state_nxt = ST_DRAIN;
      ST_DRAIN: if (count == 2'd0) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State, address pointer and checksum registers.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      checksum <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        ptr      <= '0;
        checksum <= '0;
      end else begin
        if (capture)              ptr      <= ptr_adv;
        else if (state == ST_DONE) ptr     <= '0;
        if (fire)                 checksum <= checksum ^ out_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench: a 32-register and a 5-register dump reader share one
// register array; a per-instance stream model predicts every output word.
module tb_regfile_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_all;
  logic [31:0] regs [32];

  logic        start0, rdy0, ov0, ol0, busy0, done0;
  logic [4:0]  r0a0, r1a0, oa0;
  logic [31:0] r0d0, r1d0, od0, ck0;
  logic        start5, rdy5, ov5, ol5, busy5, done5;
  logic [4:0]  r0a5, r1a5, oa5;
  logic [31:0] r0d5, r1d5, od5, ck5;

  assign r0d0 = regs[r0a0];
  assign r1d0 = regs[r1a0];
  assign r0d5 = regs[r0a5];
  assign r1d5 = regs[r1a5];

  regfile_dump_reader dut (
    .clk(clk), .rst_all(rst_all), .start(start0),
    .read0_addr(r0a0), .read1_addr(r1a0), .read0_data(r0d0), .read1_data(r1d0),
    .out_valid(ov0), .out_ready(rdy0), .out_addr(oa0), .out_data(od0),
    .out_last(ol0), .busy(busy0), .done(done0), .checksum(ck0)
  );

  regfile_dump_reader #(.NUM_REGS(5)) dut5 (
    .clk(clk), .rst_all(rst_all), .start(start5),
    .read0_addr(r0a5), .read1_addr(r1a5), .read0_data(r0d5), .read1_data(r1d5),
    .out_valid(ov5), .out_ready(rdy5), .out_addr(oa5), .out_data(od5),
    .out_last(ol5), .busy(busy5), .done(done5), .checksum(ck5)
  );

  int checks, failures;

  // Stream model per instance: a dump is "every register, in address order,
  // as it stood when start was accepted", checksum = XOR of words taken so far.
  int          active [2];
  int          cyc [2];
  int          nxt [2];
  int          xfers [2];
  int          dones [2];
  int          post [2];
  int          after_rst [2];
  int          prev_fire [2];
  logic [31:0] mck [2];
  logic [31:0] snap [2][32];
  logic [31:0] seen [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon(input int id, input int n, input logic rst, input logic st,
                     input logic rdy, input logic valid, input logic last,
                     input logic bsy, input logic dn, input logic [4:0] addr,
                     input logic [31:0] data, input logic [31:0] ck);
    logic empty, fire;
    if (after_rst[id] != 0) begin
      check("rst_busy", bsy, 0);
      check("rst_valid", valid, 0);
      check("rst_checksum", ck, 0);
      after_rst[id] = 0;
    end
    check("checksum", ck, mck[id]);
    empty = (nxt[id] >= n);
    if (valid) begin
      if (active[id] == 0 || empty) check("unexpected_valid", valid, 0);
      else begin
        check("out_addr", addr, nxt[id]);
        check("out_data", data, snap[id][nxt[id]]);
        check("out_last", last, (nxt[id] == n - 1));
      end
    end
    if (active[id] != 0 && cyc[id] == 1) check("latency_c1", valid, 0);
    if (active[id] != 0 && cyc[id] == 2) check("latency_c2", valid, 1);
    if (prev_fire[id] != 0 && active[id] != 0 && !empty) check("throughput", valid, 1);
    if (dn) begin
      check("done_expected", (active[id] != 0) && empty, 1);
      check("done_busy", bsy, 0);
    end else if (active[id] == 0) check("idle_busy", bsy, 0);
    else if (!empty) check("busy", bsy, 1);

    fire = valid && rdy && (active[id] != 0) && !empty;
    prev_fire[id] = fire;
    if (fire) begin
      mck[id] = mck[id] ^ data;
      if (id == 0) seen[addr] = data;
      nxt[id]++;
      xfers[id]++;
    end
    if (active[id] != 0) cyc[id]++;
    if (dn && active[id] != 0 && empty) begin
      active[id] = 0;
      dones[id]++;
    end else if (active[id] != 0 && empty) begin
      post[id]++;
      if (post[id] > 6) begin
        check("done_timeout", post[id], 6);
        active[id] = 0;
      end
    end
    if (st && active[id] == 0 && !dn) begin
      active[id] = 1;
      cyc[id]    = 1;
      nxt[id]    = 0;
      xfers[id]  = 0;
      post[id]   = 0;
      mck[id]    = '0;
      for (int k = 0; k < 32; k++) snap[id][k] = regs[k];
    end
    if (rst) begin
      active[id]    = 0;
      nxt[id]       = n;
      mck[id]       = '0;
      after_rst[id] = 1;
      prev_fire[id] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, 32, rst_all, start0, rdy0, ov0, ol0, busy0, done0, oa0, od0, ck0);
    mon(1, 5, rst_all, start5, rdy5, ov5, ol5, busy5, done5, oa5, od5, ck5);
  end

  task automatic drive(input int id, input logic st, input logic rdy);
    if (id == 0) begin start0 = st; rdy0 = rdy; end
    else         begin start5 = st; rdy5 = rdy; end
  endtask

  // mode: 0 ready held high, 1 ready toggling 1,0,1,0, 2 random ready.
  // start_at / rst_at: pulse start / rst_all once that many words have moved.
  task automatic run_dump(input int id, input int mode, input int start_at, input int rst_at);
    int   budget, ph;
    logic r;
    @(posedge clk); #1 drive(id, 1'b1, 1'b1);
    @(posedge clk); #1 drive(id, 1'b0, 1'b1);
    budget = 0;
    ph     = 0;
    while (active[id] != 0 && budget < 1000) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (ph[0] == 1'b0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      drive(id, (start_at > 0 && xfers[id] == start_at), r);
      rst_all = (rst_at > 0 && xfers[id] == rst_at);
      @(posedge clk); #1;
      ph++;
      budget++;
    end
    rst_all = 1'b0;
    drive(id, 1'b0, 1'b1);
    check("dump_finished", active[id], 0);
  endtask

  task automatic randomize_regs();
    for (int k = 0; k < 32; k++) regs[k] = $urandom;
  endtask

  logic [31:0] c1, old3, x5;

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 2; i++) begin
      active[i] = 0; cyc[i] = 0; xfers[i] = 0; dones[i] = 0; post[i] = 0;
      after_rst[i] = 0; prev_fire[i] = 0; mck[i] = '0;
    end
    nxt[0] = 32;
    nxt[1] = 5;
    for (int k = 0; k < 32; k++) begin
      regs[k] = '0;
      seen[k] = '0;
    end
    rst_all = 1'b1;
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_all = 1'b0;

    // Reset state.
    @(negedge clk);
    check("reset_read0_addr", r0a0, 0);
    check("reset_read1_addr", r1a0, 1);
    check("reset_out_valid", ov0, 0);
    check("reset_out_addr", oa0, 0);
    check("reset_out_data", od0, 0);
    check("reset_out_last", ol0, 0);
    check("reset_done", done0, 0);
    check("reset5_out_valid", ov5, 0);

    // Two known registers, ready held high.
    regs[1]  = 32'h5ADFACED;
    regs[21] = 32'hEA770A57;
    run_dump(0, 0, 0, 0);
    check("t1_words", xfers[0], 32);
    check("t1_dones", dones[0], 1);
    check("t1_word1", seen[1], 32'h5ADFACED);
    check("t1_word21", seen[21], 32'hEA770A57);
    check("t1_checksum", ck0, 32'hB0A8A6BA);
    repeat (3) @(negedge clk);
    check("t1_checksum_hold", ck0, 32'hB0A8A6BA);

    // Same state, toggling ready.
    run_dump(0, 1, 0, 0);
    check("t2_words", xfers[0], 32);
    check("t2_dones", dones[0], 2);
    check("t2_checksum", ck0, 32'hB0A8A6BA);

    // start pulsed mid-dump is ignored.
    run_dump(0, 0, 5, 0);
    check("t3_words", xfers[0], 32);
    check("t3_dones", dones[0], 3);

    // Reset mid-dump, then a fresh dump from address 0.
    run_dump(0, 0, 0, 10);
    check("t4_no_done", dones[0], 3);
    run_dump(0, 2, 0, 0);
    check("t4_words", xfers[0], 32);
    check("t4_dones", dones[0], 4);
    check("t4_checksum", ck0, 32'hB0A8A6BA);

    // Five-register instance with random contents.
    randomize_regs();
    run_dump(1, 2, 0, 0);
    x5 = regs[0] ^ regs[1] ^ regs[2] ^ regs[3] ^ regs[4];
    check("t5_words", xfers[1], 5);
    check("t5_dones", dones[1], 1);
    check("t5_checksum", ck5, x5);

    // Back-to-back dumps with r3 rewritten between them.
    randomize_regs();
    run_dump(0, 0, 0, 0);
    c1      = ck0;
    old3    = regs[3];
    regs[3] = 32'h00000001;
    run_dump(0, 2, 0, 0);
    check("t6_checksum_delta", ck0, c1 ^ 32'h00000001 ^ old3);

    // Random contents and random back-pressure on both instances.
    repeat (3) begin
      randomize_regs();
      run_dump(0, 2, 0, 0);
      check("rand_words", xfers[0], 32);
      run_dump(1, 2, 0, 0);
      check("rand5_words", xfers[1], 5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
